// File: rtl/lsu_pipe_if.sv
// Shared op type and the request/response/DBus bundle for lsu_pipe.
//
// lsu_pipe_pkg::lsu_op_t : 4-bit operation code. Codes 9..15 and LSU_NOP are non-memory ops.
// lsu_pipe_if #(XLEN)     : groups the core request, response and DBus signals.
//   slave  modport : the LSU side (used by lsu_pipe)
//   master modport : the core/bus-model side (used by a driver or testbench)
//   Signals: req_valid/req_ready/req_op/req_addr/req_wdata/endianness/flush,
//            rsp_valid/rsp_data/rsp_misaligned/rsp_fault,
//            dbus_rd_en/dbus_wr_en/dbus_addr/dbus_wr_data/dbus_wr_strobe,
//            dbus_rd_data/dbus_wait/dbus_err.

package lsu_pipe_pkg;
  typedef enum logic [3:0] {
    LSU_NOP = 4'h0,
    LSU_LB  = 4'h1,
    LSU_LH  = 4'h2,
    LSU_LW  = 4'h3,
    LSU_LBU = 4'h4,
    LSU_LHU = 4'h5,
    LSU_SB  = 4'h6,
    LSU_SH  = 4'h7,
    LSU_SW  = 4'h8
  } lsu_op_t;
endpackage

interface lsu_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic                   req_valid;
  logic                   req_ready;
  lsu_pipe_pkg::lsu_op_t  req_op;
  logic [XLEN-1:0]        req_addr;
  logic [XLEN-1:0]        req_wdata;
  logic                   endianness;
  logic                   flush;

  logic                   rsp_valid;
  logic [XLEN-1:0]        rsp_data;
  logic                   rsp_misaligned;
  logic                   rsp_fault;

  logic                   dbus_rd_en;
  logic                   dbus_wr_en;
  logic [XLEN-1:0]        dbus_addr;
  logic [XLEN-1:0]        dbus_wr_data;
  logic [XLEN/8-1:0]      dbus_wr_strobe;
  logic [XLEN-1:0]        dbus_rd_data;
  logic                   dbus_wait;
  logic                   dbus_err;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, endianness, flush,
    output req_ready,
    output rsp_valid, rsp_data, rsp_misaligned, rsp_fault,
    output dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe,
    input  dbus_rd_data, dbus_wait, dbus_err
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, endianness, flush,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_misaligned, rsp_fault,
    input  dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe,
    output dbus_rd_data, dbus_wait, dbus_err
  );
endinterface

// File: rtl/lsu_pipe.sv
// Load/store unit pipeline: accepts one core request at a time, runs it on the DBus with
// byte-lane alignment, wait-state handling and a timeout, and returns a one-cycle response.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_pipe_if.slave (request, response and DBus signals)
// Parameters:
//   XLEN    : data/address width, 32 or 64
//   TIMEOUT : consecutive dbus_wait cycles tolerated before a fault, 1..255
// Configuration macro:
//   LSU_PIPE_BIG_ENDIAN_EN : when defined, endianness=1 byte-reverses the accessed halfword
//                            or word on load extract and store insert; otherwise the
//                            endianness input is ignored (little-endian only).

module lsu_pipe
  import lsu_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_n,
  lsu_pipe_if.slave bus
);

  localparam int unsigned NBYTES      = XLEN / 8;
  localparam int unsigned OFFW        = $clog2(NBYTES);
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Access size in bytes; 0 marks a non-memory op.
  function automatic logic [2:0] op_size(lsu_op_t op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: op_size = 3'd1;
      LSU_LH, LSU_LHU, LSU_SH: op_size = 3'd2;
      LSU_LW, LSU_SW:          op_size = 3'd4;
      default:                 op_size = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_load(lsu_op_t op);
    op_is_load = op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

  logic [1:0]      state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  lsu_op_t         op_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_mis_q, rsp_mis_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic            accept;

  // Byte-swap select for the registered request.
  logic be;
`ifdef LSU_PIPE_BIG_ENDIAN_EN
  logic endian_q;
  assign be = endian_q;
`else
  logic unused_endianness;
  assign be                = 1'b0;
  assign unused_endianness = bus.endianness;
`endif

  // Accept-side decode, used to choose between BUS and an immediate response.
  logic [2:0] req_size;
  logic       req_mis;
  assign req_size = op_size(bus.req_op);
  assign req_mis  = ((req_size == 3'd2) && bus.req_addr[0]) ||
                    ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));

  // Registered-request decode.
  logic [2:0]      q_size;
  logic            q_load, q_store;
  logic [OFFW-1:0] off;
  assign q_size  = op_size(op_q);
  assign q_load  = op_is_load(op_q);
  assign q_store = (q_size != 3'd0) && !q_load;
  assign off     = addr_q[OFFW-1:0];

  // Store path: build the (optionally byte-reversed) element, then move it to its lanes.
  logic [31:0]       st_elem;
  logic [NBYTES-1:0] st_mask;
  always_comb begin
    st_elem = '0;
    st_mask = '0;
    case (q_size)
      3'd1: begin
        st_elem = {24'b0, wdata_q[7:0]};
        st_mask = NBYTES'(4'h1);
      end
      3'd2: begin
        st_elem = be ? {16'b0, wdata_q[7:0], wdata_q[15:8]} : {16'b0, wdata_q[15:0]};
        st_mask = NBYTES'(4'h3);
      end
      3'd4: begin
        st_elem = be ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]}
                     : wdata_q[31:0];
        st_mask = NBYTES'(4'hF);
      end
      default: ;
    endcase
  end

  // Load path: shift the addressed lanes down, optionally reverse, then extend.
  logic [XLEN-1:0] rd_lanes;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_w;
  logic [XLEN-1:0] ld_val;
  assign rd_lanes = bus.dbus_rd_data >> {off, 3'b000};
  assign ld_b     = rd_lanes[7:0];
  assign ld_h     = be ? {rd_lanes[7:0], rd_lanes[15:8]} : rd_lanes[15:0];
  assign ld_w     = be ? {rd_lanes[7:0], rd_lanes[15:8], rd_lanes[23:16], rd_lanes[31:24]}
                       : rd_lanes[31:0];

  always_comb begin
    ld_val = '0;
    case (op_q)
      LSU_LB:  ld_val = XLEN'($signed(ld_b));
      LSU_LBU: ld_val = XLEN'(ld_b);
      LSU_LH:  ld_val = XLEN'($signed(ld_h));
      LSU_LHU: ld_val = XLEN'(ld_h);
      LSU_LW:  ld_val = XLEN'($signed(ld_w));
      default: ld_val = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_fault_d = rsp_fault_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept      = 1'b1;
          wait_cnt_d  = '0;
          rsp_data_d  = '0;
          rsp_mis_d   = req_mis;
          rsp_fault_d = 1'b0;
          state_d     = ((req_size != 3'd0) && !req_mis) ? ST_BUS : ST_RESP;
        end
      end
      ST_BUS: begin
        // Error beats both completion and wait; a completing beat beats the timeout.
        if (bus.dbus_err) begin
          rsp_fault_d = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else if (!bus.dbus_wait) begin
          rsp_data_d = ld_val;
          state_d    = ST_RESP;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          rsp_fault_d = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      op_q        <= LSU_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_fault_q <= rsp_fault_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

`ifdef LSU_PIPE_BIG_ENDIAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      endian_q <= 1'b0;
    end else if (accept) begin
      endian_q <= bus.endianness;
    end
  end
`endif

  // Outputs. Flush masks the bus and response combinationally in the same cycle.
  logic bus_active;
  assign bus_active = (state_q == ST_BUS) && !bus.flush;

  assign bus.req_ready      = (state_q == ST_IDLE) && !bus.flush;
  assign bus.dbus_rd_en     = bus_active && q_load;
  assign bus.dbus_wr_en     = bus_active && q_store;
  assign bus.dbus_addr      = bus_active ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign bus.dbus_wr_data   = bus.dbus_wr_en ? (XLEN'(st_elem) << {off, 3'b000}) : '0;
  assign bus.dbus_wr_strobe = bus.dbus_wr_en ? (st_mask << off) : '0;

  assign bus.rsp_valid      = (state_q == ST_RESP) && !bus.flush;
  assign bus.rsp_data       = bus.rsp_valid ? rsp_data_q : '0;
  assign bus.rsp_misaligned = bus.rsp_valid && rsp_mis_q;
  assign bus.rsp_fault      = bus.rsp_valid && rsp_fault_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Self-checking bench for lsu_pipe (XLEN=32, TIMEOUT=3): directed cases followed by random
// transactions scored against a byte-level reference model.

module tb_lsu_pipe;
  import lsu_pipe_pkg::*;

  localparam int unsigned TB_TIMEOUT = 3;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  lsu_pipe_if #(.XLEN(32)) bus_if ();

  lsu_pipe #(
    .XLEN    (32),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the access rules: byte lanes, alignment and wait/err/timeout order.
  function automatic void model(input lsu_op_t op, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit endian,
                                input logic [31:0] rd, input int w, input int e,
                                output logic [31:0] m_data, output bit m_mis,
                                output bit m_fault, output int m_lat, output int m_buscyc,
                                output logic [3:0] m_strb, output logic [31:0] m_wd);
    int         size;
    int         off;
    int         lane;
    int         src;
    bit         is_load;
    bit         is_signed;
    bit         be;
    logic [63:0] v;
    size      = (op inside {LSU_LB, LSU_LBU, LSU_SB}) ? 1 :
                (op inside {LSU_LH, LSU_LHU, LSU_SH}) ? 2 :
                (op inside {LSU_LW, LSU_SW}) ? 4 : 0;
    is_load   = op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    is_signed = op inside {LSU_LB, LSU_LH, LSU_LW};
`ifdef LSU_PIPE_BIG_ENDIAN_EN
    be = endian;
`else
    be = 1'b0;
`endif
    off     = int'(addr % 4);
    m_data  = '0;
    m_fault = 1'b0;
    m_strb  = '0;
    m_wd    = '0;
    m_mis   = (size > 1) && ((addr % size) != 0);
    if (size == 0 || m_mis) begin
      m_lat    = 1;
      m_buscyc = 0;
      return;
    end
    if (!is_load) begin
      for (int k = 0; k < size; k++) begin
        lane            = off + k;
        src             = be ? size - 1 - k : k;
        m_strb[lane]    = 1'b1;
        m_wd[8*lane+:8] = wdata[8*src+:8];
      end
    end
    m_lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (i == e) begin
        m_fault = 1'b1;
        m_lat   = i + 2;
        break;
      end
      if (i >= w) begin
        m_lat = i + 2;
        break;
      end
      if (i == TB_TIMEOUT) begin
        m_fault = 1'b1;
        m_lat   = i + 2;
        break;
      end
    end
    m_buscyc = m_lat - 1;
    if (is_load && !m_fault) begin
      v = '0;
      for (int k = 0; k < size; k++) begin
        lane = off + k;
        src  = be ? size - 1 - k : k;
        v    = v | (64'(rd[8*lane+:8]) << (8 * src));
      end
      if (is_signed && v[8*size-1]) v = v - (64'd1 << (8 * size));
      m_data = v[31:0];
    end
  endfunction

  // Observations from the most recent run_txn.
  logic [31:0] obs_addr, obs_wd, obs_data;
  logic [3:0]  obs_strb;
  bit          obs_mis, obs_fault;
  int          obs_lat, obs_buscyc;

  // Issue one request from IDLE (entered at posedge+1) and follow it to its response.
  task automatic run_txn(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit endian, input logic [31:0] rd, input int w, input int e);
    logic [31:0] m_data, m_wd;
    logic [3:0]  m_strb;
    bit          m_mis, m_fault, got, is_load;
    int          m_lat, m_buscyc, cyc, idx;
    model(op, addr, wdata, endian, rd, w, e, m_data, m_mis, m_fault, m_lat, m_buscyc,
          m_strb, m_wd);
    is_load = op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    bus_if.req_valid  = 1'b1;
    bus_if.req_op     = op;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.endianness = endian;
    bus_if.flush      = 1'b0;
    #3;
    check("req_ready", 64'(bus_if.req_ready), 64'd1);
    next_cycle();
    bus_if.req_valid = 1'b0;
    obs_addr   = '0;
    obs_wd     = '0;
    obs_strb   = '0;
    obs_data   = '0;
    obs_mis    = 1'b0;
    obs_fault  = 1'b0;
    obs_lat    = -1;
    got        = 1'b0;
    cyc        = 1;
    idx        = 0;
    while (!got && cyc <= 40) begin
      bus_if.dbus_wait    = (idx < w);
      bus_if.dbus_err     = (idx == e);
      bus_if.dbus_rd_data = rd;
      #3;
      if (bus_if.dbus_rd_en || bus_if.dbus_wr_en) begin
        if (idx == 0) begin
          check("rd_en_sel", 64'(bus_if.dbus_rd_en), 64'(is_load));
          check("wr_en_sel", 64'(bus_if.dbus_wr_en), 64'(!is_load));
          check("dbus_addr", 64'(bus_if.dbus_addr), 64'(addr & 32'hFFFF_FFFC));
          check("wr_strobe", 64'(bus_if.dbus_wr_strobe), 64'(m_strb));
          check("wr_data", 64'(bus_if.dbus_wr_data), 64'(m_wd));
          obs_addr = bus_if.dbus_addr;
          obs_wd   = bus_if.dbus_wr_data;
          obs_strb = bus_if.dbus_wr_strobe;
        end
        idx++;
      end
      if (bus_if.rsp_valid) begin
        got       = 1'b1;
        obs_lat   = cyc;
        obs_data  = bus_if.rsp_data;
        obs_mis   = bus_if.rsp_misaligned;
        obs_fault = bus_if.rsp_fault;
        check("rsp_data", 64'(obs_data), 64'(m_data));
        check("rsp_misaligned", 64'(obs_mis), 64'(m_mis));
        check("rsp_fault", 64'(obs_fault), 64'(m_fault));
      end else begin
        check("rsp_idle_zero",
              64'({bus_if.rsp_data, bus_if.rsp_misaligned, bus_if.rsp_fault}), 64'd0);
      end
      next_cycle();
      cyc++;
    end
    bus_if.dbus_wait = 1'b0;
    bus_if.dbus_err  = 1'b0;
    obs_buscyc       = idx;
    check("latency", 64'(obs_lat), 64'(m_lat));
    check("bus_cycles", 64'(obs_buscyc), 64'(m_buscyc));
  endtask

  lsu_op_t     rop;
  int          rw, re;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_if.req_valid    = 1'b0;
    bus_if.req_op       = LSU_NOP;
    bus_if.req_addr     = '0;
    bus_if.req_wdata    = '0;
    bus_if.endianness   = 1'b0;
    bus_if.flush        = 1'b0;
    bus_if.dbus_rd_data = '0;
    bus_if.dbus_wait    = 1'b0;
    bus_if.dbus_err     = 1'b0;

    // Reset state.
    #2;
    check("reset_req_ready", 64'(bus_if.req_ready), 64'd1);
    check("reset_rsp", 64'({bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_misaligned,
                            bus_if.rsp_fault}), 64'd0);
    check("reset_dbus", 64'({bus_if.dbus_rd_en, bus_if.dbus_wr_en, bus_if.dbus_wr_strobe}),
          64'd0);
    check("reset_dbus_addr", 64'(bus_if.dbus_addr), 64'd0);
    check("reset_dbus_wdata", 64'(bus_if.dbus_wr_data), 64'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Aligned word load, no wait.
    run_txn(LSU_LW, 32'h1000, 32'h0, 1'b0, 32'h8899_AABB, 0, -1);
    check("lw_latency", 64'(obs_lat), 64'd2);
    check("lw_data", 64'(obs_data), 64'h8899_AABB);

    // Byte store into the top lane.
    run_txn(LSU_SB, 32'h1003, 32'h0000_00A5, 1'b0, 32'h0, 0, -1);
    check("sb_addr", 64'(obs_addr), 64'h1000);
    check("sb_strobe", 64'(obs_strb), 64'h8);
    check("sb_wdata", 64'(obs_wd), 64'hA500_0000);

    // Misaligned halfword: immediate response, never on the bus.
    run_txn(LSU_LH, 32'h1001, 32'h0, 1'b0, 32'hFFFF_FFFF, 0, -1);
    check("lh_mis_flag", 64'(obs_mis), 64'd1);
    check("lh_mis_latency", 64'(obs_lat), 64'd1);
    check("lh_mis_no_rd", 64'(obs_buscyc), 64'd0);

    // Timeout with wait held high, then error during wait.
    run_txn(LSU_LW, 32'h1000, 32'h0, 1'b0, 32'h1234_5678, 100, -1);
    check("timeout_fault", 64'(obs_fault), 64'd1);
    run_txn(LSU_LW, 32'h1000, 32'h0, 1'b0, 32'h1234_5678, 100, 1);
    check("err_fault", 64'(obs_fault), 64'd1);
    check("err_latency", 64'(obs_lat), 64'd3);

    // Non-memory op.
    run_txn(lsu_op_t'(4'hC), 32'h1000, 32'h55, 1'b0, 32'hFFFF_FFFF, 0, -1);
    check("nop_latency", 64'(obs_lat), 64'd1);

    // Endianness on LHU.
    run_txn(LSU_LHU, 32'h1002, 32'h0, 1'b1, 32'h1234_0000, 0, -1);
`ifdef LSU_PIPE_BIG_ENDIAN_EN
    check("lhu_endian", 64'(obs_data), 64'h0000_3412);
`else
    check("lhu_endian", 64'(obs_data), 64'h0000_1234);
`endif

    // Flush in the second BUS cycle of a waiting load.
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = LSU_LW;
    bus_if.req_addr  = 32'h2000;
    bus_if.dbus_wait = 1'b1;
    next_cycle();
    bus_if.req_valid = 1'b0;
    #3;
    check("flush_bus1_rd_en", 64'(bus_if.dbus_rd_en), 64'd1);
    next_cycle();
    bus_if.flush = 1'b1;
    #3;
    check("flush_en_drop", 64'({bus_if.dbus_rd_en, bus_if.dbus_wr_en}), 64'd0);
    check("flush_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
    next_cycle();
    bus_if.flush = 1'b0;
    #3;
    check("flush_ready_next", 64'(bus_if.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("flush_quiet", 64'({bus_if.rsp_valid, bus_if.dbus_rd_en}), 64'd0);
      next_cycle();
      #3;
    end
    next_cycle();
    bus_if.dbus_wait = 1'b0;

    // Reset asserted mid-transaction.
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = LSU_SW;
    bus_if.req_addr  = 32'h3000;
    bus_if.dbus_wait = 1'b1;
    next_cycle();
    bus_if.req_valid = 1'b0;
    #3;
    check("rst_mid_wr_en", 64'(bus_if.dbus_wr_en), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_en_drop", 64'({bus_if.dbus_rd_en, bus_if.dbus_wr_en}), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    bus_if.dbus_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("rst_mid_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
      next_cycle();
    end

    // Random transactions.
    for (int n = 0; n < 150; n++) begin
      rop = lsu_op_t'(4'($urandom_range(0, 15)));
      rw  = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(0, 4));
      re  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_txn(rop, $urandom, $urandom, 1'($urandom), $urandom, rw, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_pipe.md
LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum consecutive dbus_wait cycles before a fault; legal range 1..255.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  lsu_op_t  operation (LSU_LB/LH/LW/LBU/LHU/SB/SH/SW; others are non-memory).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- endianness  in  1  0=little, 1=big; sampled at accept.
- flush  in  1  abort any in-flight request.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  XLEN  load result, sign/zero-extended; 0 for stores, errors and non-memory ops.
- rsp_misaligned  out  1  response is a misalignment exception.
- rsp_fault  out  1  response is a bus error or timeout.
- dbus_rd_en, dbus_wr_en  out  1 each  DBus read/write enables.
- dbus_addr  out  XLEN  address aligned down to XLEN/8 bytes.
- dbus_wr_data  out  XLEN  store data shifted to its byte lanes.
- dbus_wr_strobe  out  XLEN/8  active byte lanes.
- dbus_rd_data  in  XLEN  read data.
- dbus_wait  in  1  transaction needs another cycle.
- dbus_err  in  1  transaction aborted.

Function
REQ-004 SHALL implement FSM IDLE, BUS, RESP; req_ready=1 only in IDLE with flush=0.
REQ-005 SHALL, in IDLE on req_valid&req_ready, register op, addr, wdata and endianness; next state BUS for an aligned memory op, RESP otherwise.
REQ-006 SHALL flag misaligned when a halfword has addr[0]=1 or a word has addr[1:0]!=0; the response then has rsp_misaligned=1 and no DBus enable is asserted.
REQ-007 SHALL, in BUS, drive dbus_rd_en (loads) or dbus_wr_en (stores) from the registered request; both enables are 0 in every other state.
REQ-008 SHALL set dbus_wr_strobe to 1, 3 or F shifted left by addr offset (addr mod XLEN/8), and dbus_wr_data to the store element shifted left by 8*offset.
REQ-009 SHALL extract load data from dbus_rd_data lanes at the same offset, then sign- or zero-extend it to XLEN.
REQ-010 SHALL hold in BUS while dbus_wait=1, incrementing an 8-bit wait counter that clears on entry to BUS.
REQ-011 SHALL leave BUS for RESP when dbus_wait=0 (capturing data), when dbus_err=1 (rsp_fault=1; dbus_err wins over dbus_wait), or when the wait counter equals TIMEOUT (rsp_fault=1).
REQ-012 SHALL assert rsp_valid for exactly one cycle in RESP, with registered rsp_* values, then return to IDLE.
REQ-013 SHALL give a latency of 2 cycles from accept to rsp_valid with zero wait, plus 1 cycle per wait cycle; misaligned and non-memory requests respond in 1 cycle.
REQ-014 SHALL, on flush=1 in any state, force next state IDLE, suppress rsp_valid and zero the DBus enables combinationally in that cycle.
REQ-015 SHALL hold rsp_data/rsp_misaligned/rsp_fault at 0 whenever rsp_valid=0.

Reset
REQ-016 SHALL, while rst_n=0, set state IDLE, the wait counter and all registered request/response fields to 0; outputs are then req_ready=1 and all other outputs 0.
REQ-017 SHALL, on reset asserted mid-transaction, drop the DBus enables immediately and produce no response.

Configuration
REQ-018 SHALL honour macro LSU_PIPE_BIG_ENDIAN_EN: when defined, endianness=1 byte-reverses the accessed element (halfword or word) on both load extract and store insert; when undefined, the endianness port is ignored and operation is little-endian only.

Verification
REQ-019 SHALL cover: XLEN=32, LW addr 0x1000, dbus_rd_data 0x8899AABB, no wait -> rsp_valid 2 cycles after accept, rsp_data 0x8899AABB.
REQ-020 SHALL cover: SB addr 0x1003, wdata 0x000000A5 -> dbus_addr 0x1000, strobe 4'h8, wr_data 0xA5000000.
REQ-021 SHALL cover: LH addr 0x1001 -> rsp_misaligned=1 after 1 cycle, no dbus_rd_en ever asserted.
REQ-022 SHALL cover: LW with dbus_wait held high, TIMEOUT=3 -> rsp_fault=1 after 3 wait cycles; dbus_err=1 with wait=1 -> rsp_fault next cycle.
REQ-023 SHALL cover: flush in BUS cycle 2 of a wait -> enables drop that cycle, no rsp_valid, req_ready=1 next cycle.
REQ-024 SHALL cover: with LSU_PIPE_BIG_ENDIAN_EN, endianness=1, LHU addr 0x1002, rd_data 0x12340000 -> rsp_data 0x00003412.
